// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 8 requesters with registered active-low one-hot grants,
// a per-grant hold limit and an all-deasserted guard gap between owners.
module rr_decode_arbiter #(
  parameter int unsigned MAX_HOLD  = 16,
  parameter int unsigned GUARD_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt_n,
  output logic [2:0] sel,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned HW = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [3:0]    GUARD_INIT = 4'(GUARD_CYC - 1);
  localparam bit            HOLD_LIMIT = (MAX_HOLD != 0);

  typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

  state_t        state, state_nxt;
  logic [2:0]    ptr, ptr_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [3:0]    guard_cnt, guard_nxt;
  logic [7:0]    gnt_n_nxt;
  logic [2:0]    sel_nxt;
  logic          gnt_valid_nxt, timeout_nxt;

  logic          found;
  logic [2:0]    pick;
  logic          rel_req, rel_en, rel_hold;

  // Rotating scan: the requester just after the last grantee has top priority.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= 8; i++) begin
      if (!found && req[ptr + 3'(i)]) begin
        found = 1'b1;
        pick  = ptr + 3'(i);
      end
    end
  end

  assign rel_req  = !req[sel];
  assign rel_en   = !en;
  assign rel_hold = HOLD_LIMIT && (hold_cnt == HOLD_LAST);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    hold_nxt      = hold_cnt;
    guard_nxt     = guard_cnt;
    gnt_n_nxt     = gnt_n;
    sel_nxt       = sel;
    gnt_valid_nxt = gnt_valid;
    timeout_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (en && found) begin
          state_nxt     = GRANT;
          gnt_n_nxt     = ~(8'h01 << pick);
          sel_nxt       = pick;
          gnt_valid_nxt = 1'b1;
          hold_nxt      = '0;
        end
      end
      GRANT: begin
        if (hold_cnt != '1) hold_nxt = hold_cnt + 1'b1;
        if (rel_req || rel_en || rel_hold) begin
          state_nxt     = GUARD;
          gnt_n_nxt     = 8'hFF;
          gnt_valid_nxt = 1'b0;
          ptr_nxt       = sel;
          guard_nxt     = GUARD_INIT;
          // Flag a timeout only when the hold limit alone forced the release.
          timeout_nxt   = rel_hold && !rel_req && !rel_en;
        end
      end
      GUARD: begin
        if (guard_cnt == '0) state_nxt = IDLE;
        else                 guard_nxt = guard_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd7;
      hold_cnt  <= '0;
      guard_cnt <= '0;
      gnt_n     <= 8'hFF;
      sel       <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      guard_cnt <= guard_nxt;
      gnt_n     <= gnt_n_nxt;
      sel       <= sel_nxt;
      gnt_valid <= gnt_valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Scoreboard bench: a cycle-level ownership model predicts outputs after every edge,
// and a negedge monitor compares them against the arbiter.
module tb_rr_decode_arbiter;

  localparam int MAX_HOLD  = 4;
  localparam int GUARD_CYC = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt_n;
  logic [2:0] sel;
  logic       gnt_valid;
  logic       timeout;

  rr_decode_arbiter #(.MAX_HOLD(MAX_HOLD), .GUARD_CYC(GUARD_CYC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .gnt_n    (gnt_n),
    .sel      (sel),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] gnt_n;
    logic [2:0] sel;
    logic       vld;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Model: who owns the resource, for how many cycles, how much gap is left.
  int         m_owner;
  int         m_held;
  int         m_gap;
  int         m_last;
  logic [2:0] m_sel;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t model_out(input logic to);
    exp_t x;
    x.gnt_n = (m_owner >= 0) ? ~(8'h01 << m_owner) : 8'hFF;
    x.sel   = m_sel;
    x.vld   = (m_owner >= 0);
    x.to    = to;
    return x;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_gap   = 0;
    m_last  = 7;
    m_sel   = 3'd0;
  endtask

  task automatic model_step(input logic e, input logic [7:0] r, output exp_t x);
    logic to;
    logic cut_req, cut_en, cut_hold, done;
    int   k;
    to = 1'b0;
    if (m_owner >= 0) begin
      cut_req  = !r[m_owner];
      cut_en   = !e;
      cut_hold = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
      if (cut_req || cut_en || cut_hold) begin
        to      = cut_hold && !cut_req && !cut_en;
        m_last  = m_owner;
        m_owner = -1;
        m_gap   = GUARD_CYC;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (e && r != 8'h00) begin
      done = 1'b0;
      for (int i = 1; i <= 8; i++) begin
        k = (m_last + i) % 8;
        if (!done && r[k]) begin
          done    = 1'b1;
          m_owner = k;
          m_held  = 1;
          m_sel   = 3'(k);
        end
      end
    end
    x = model_out(to);
  endtask

  // Entered and left at negedge+1: drive inputs, predict the next edge, queue it.
  task automatic cycle(input logic e, input logic [7:0] r);
    exp_t x;
    en  = e;
    req = r;
    model_step(e, r, x);
    sb.push_back(x);
    @(negedge clk);
    #1;
  endtask

  // Asserts reset between edges, checks the immediate drop, releases it one cycle later.
  task automatic pulse_reset();
    #3;
    sb.delete();
    en    = 1'b0;
    req   = 8'h00;
    rst_n = 1'b0;
    model_reset();
    sb.push_back(model_out(1'b0));
    #1;
    check("rst_gnt_n",   16'(gnt_n),     16'h00FF);
    check("rst_valid",   16'(gnt_valid), 16'h0000);
    check("rst_timeout", 16'(timeout),   16'h0000);
    check("rst_sel",     16'(sel),       16'h0000);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("scoreboard {gnt_n,sel,vld,to}",
              16'({gnt_n, sel, gnt_valid, timeout}), 16'(e));
      end
    end
  end

  initial begin : stimulus
    logic [7:0] r;
    rst_n = 1'b1;
    en    = 1'b0;
    req   = 8'h00;
    model_reset();
    @(negedge clk);
    #1;
    pulse_reset();

    // Single requester 3, then drop.
    repeat (3) cycle(1'b1, 8'h08);
    repeat (3) cycle(1'b1, 8'h00);

    // All requesting from fresh reset: order 0..7,0 with timeouts and 2-cycle gaps.
    pulse_reset();
    repeat (56) cycle(1'b1, 8'hFF);
    repeat (3) cycle(1'b1, 8'h00);

    // Requester 0 alone: timed out after MAX_HOLD, re-granted after the gap.
    repeat (14) cycle(1'b1, 8'h01);
    repeat (3) cycle(1'b1, 8'h00);

    // Grant to 5, then disable: release without timeout, no new grants while en=0.
    for (int i = 0; i < 10 && m_owner != 5; i++) cycle(1'b1, 8'h20);
    cycle(1'b1, 8'h20);
    repeat (10) cycle(1'b0, 8'hFF);
    repeat (3) cycle(1'b1, 8'h00);

    // req[2] drops in the cycle the hold limit is reached: no timeout.
    for (int i = 0; i < 20; i++) begin
      if (m_owner == 2 && m_held == MAX_HOLD) begin
        cycle(1'b1, 8'h00);
        break;
      end
      cycle(1'b1, 8'h04);
    end
    repeat (3) cycle(1'b1, 8'h00);

    // Reset mid-grant; afterwards requester 0 wins against 7.
    for (int i = 0; i < 10 && m_owner < 0; i++) cycle(1'b1, 8'h81);
    cycle(1'b1, 8'h81);
    pulse_reset();
    repeat (6) cycle(1'b1, 8'h81);

    // Randomized traffic with sticky requests and occasional disables.
    r = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) r = 8'($urandom) & 8'($urandom);
      if (i == 200) pulse_reset();
      cycle($urandom_range(0, 15) != 0, r);
    end
    repeat (4) cycle(1'b1, 8'h00);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 16'(sb.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
